sram_responder: RTL
===================

// Module: sram_responder
// PURPOSE
// Synthesizable responder for the SRAM-style bus driven by the LC-3 fetch/Mem2IO side (CE, UB, LB, OE, WE, ADDR, Data).
// Answers that bus from an on-chip word array with configurable read latency, so the datapath runs without the external chip.
// Drop-in for the board SRAM in small LC-3 builds; a side-band init port preloads program images.
// PARAMETERS
// DEPTH     256  words implemented; word addresses >= DEPTH are out of range
// AW        8    index bits used from ADDR (log2 DEPTH)
// READ_LAT  2    cycles from accepted read to Data driven (1..7)
// PORTS
// Clk        in     1   system clock, rising edge
// Reset      in     1   asynchronous, active-low reset
// CE         in     1   chip enable, active-low
// OE         in     1   output enable, active-low
// WE         in     1   write enable, active-low; has priority over OE
// UB         in     1   upper byte lane [15:8] select, active-low
// LB         in     1   lower byte lane [7:0] select, active-low
// ADDR       in     18  word address
// Data       inout  16  bidirectional data; driven only during a valid read
// Init_En    in     1   preload strobe, active-high
// Init_Addr  in     AW  preload word address
// Init_Data  in     16  preload word, full 16 bits
// Data_Valid out    1   high while this block drives Data
// Range_Err  out    1   one-cycle pulse: access accepted with ADDR >= DEPTH
// BEHAVIOUR
// - Reset low: state IDLE, latency counter 0, Data_Valid=0, Range_Err=0, Data=Z. Array contents are NOT cleared.
// - Inputs sampled on each rising Clk. Request decode:
//   WRITE = !CE & !WE; READ = !CE & WE & !OE; otherwise NONE.
// - FSM states: IDLE, RD_WAIT, RD_DRIVE, WR.
//   IDLE -> WR on WRITE; IDLE -> RD_WAIT on READ (latch ADDR, cnt=READ_LAT-1); NONE stays IDLE.
//   RD_WAIT: cnt>0 -> decrement; cnt==0 -> RD_DRIVE. With READ_LAT=1, IDLE goes directly to RD_DRIVE.
//   RD_DRIVE: Data_Valid=1, Data = stored word.
//     Selected lanes carry data; lanes with UB/LB high read back as 8'h00.
//     Stay while READ holds with the same ADDR.
//   Any state: request becomes NONE -> IDLE. Data goes Z and Data_Valid drops at that same edge.
//   Any read state: WRITE seen -> WR. Data released at that edge; write applied same edge.
//   RD_WAIT/RD_DRIVE: ADDR change with READ held -> RD_WAIT with cnt reloaded (restart, no stale data).
//   WR: each edge with WRITE writes selected lanes of Data into ADDR.
//     Data is never driven in WR. READ -> RD_WAIT; NONE -> IDLE.
// - Read latency: READ accepted at edge k -> Data valid after edge k+READ_LAT.
// - Write latency: 0 cycles. A read of the same word accepted at the next edge returns the new value.
// - WRITE with UB=LB=1: no array change, still enters WR.
// - Out of range (ADDR[17:AW] != 0 or index >= DEPTH):
//   Range_Err pulses one cycle after the accepting edge. Writes ignored; reads follow normal timing, return 16'h0000.
//   Held request: pulse only on entry or ADDR change, not every cycle.
// - Init_En: writes Init_Data to Init_Addr at the edge, all 16 bits, regardless of bus state.
//   Simultaneous bus write to same word: Init wins.
//   Init changing the word being read: RD_DRIVE shows the new value one cycle later.
// - Data_Valid==1 exactly when Data is driven. No other path drives Data.
// - Reset asserted mid-read: Data to Z immediately (asynchronous); the write in flight at that edge is not performed.
// TESTING
// 1. Init_En writes 16'h1234 @5; READ @5 (UB=LB=0, READ_LAT=2) -> Data=16'h1234, Data_Valid=1 two edges after accept, Z before.
// 2. WRITE 16'hABCD @7 with UB=1,LB=0 over 16'h0000 -> readback 16'h00CD. Same read with LB=1 -> 16'h0000.
// 3. Read @5 held, ADDR->6 mid-RD_DRIVE -> Data=Z/restart; word@6 valid 2 edges later; no stale 16'h1234.
// 4. ADDR=18'h00100 (DEPTH=256) write then read -> Range_Err one-cycle pulse each time, array unchanged, read returns 16'h0000.
// 5. WE and OE both low with CE low -> treated as write, Data never driven (check no bus contention, Data_Valid=0).
// 6. Reset low during RD_DRIVE -> Data=Z, Data_Valid=0 same cycle. After release, earlier preloaded word still reads back.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: on-chip word array answering the LC-3 SRAM-style bus with configurable read latency
// Ports:
//   Clk, Reset          rising-edge clock, asynchronous active-low reset
//   CE, OE, WE, UB, LB  active-low bus controls (WE has priority over OE)
//   ADDR, Data          18-bit word address, 16-bit bidirectional data
//   Init_En/Addr/Data   side-band preload of full words, independent of bus state
//   Data_Valid          high exactly while Data is driven
//   Range_Err           one-cycle pulse after an access to ADDR >= DEPTH is accepted
module sram_responder #(
    parameter int DEPTH    = 256,
    parameter int AW       = 8,
    parameter int READ_LAT = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          CE,
    input  logic          OE,
    input  logic          WE,
    input  logic          UB,
    input  logic          LB,
    input  logic [17:0]   ADDR,
    inout  wire  [15:0]   Data,
    input  logic          Init_En,
    input  logic [AW-1:0] Init_Addr,
    input  logic [15:0]   Init_Data,
    output logic          Data_Valid,
    output logic          Range_Err
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR} state_t;
    localparam logic [2:0] LAT_RELOAD = 3'(READ_LAT - 1);
    localparam state_t RD_FIRST = (READ_LAT == 1) ? RD_DRIVE : RD_WAIT;
    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [17:0] addr_q, addr_d;
    logic oor_q, oor_d;
    logic [1:0] lanes_q, lanes_d;
    logic range_err_q, range_err_d;
    logic run_q;
    logic [15:0] mem [DEPTH];
    logic wr_req, rd_req, oor, restart, new_acc;
    logic [15:0] rd_word;
    always_comb begin
        wr_req      = !CE && !WE;
        rd_req      = !CE && WE && !OE;
        // Upper ADDR bits set implies ADDR >= 2**AW >= DEPTH, so one compare covers both cases.
        oor         = ADDR >= 18'(DEPTH);
        // A read (re)starts when entering from a non-read state or when the held address moves.
        restart     = rd_req && (state_q == IDLE || state_q == WR || ADDR != addr_q);
        new_acc     = (wr_req && (state_q != WR || ADDR != addr_q)) || restart;
        state_d     = !(wr_req || rd_req) ? IDLE :
                      wr_req ? WR :
                      restart ? RD_FIRST :
                      (state_q == RD_WAIT && cnt_q == 3'd0) ? RD_DRIVE : state_q;
        cnt_d       = !rd_req ? 3'd0 :
                      restart ? LAT_RELOAD :
                      (state_q == RD_WAIT && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
        addr_d      = (wr_req || rd_req) ? ADDR : addr_q;
        oor_d       = (wr_req || rd_req) ? oor : oor_q;
        lanes_d     = rd_req ? {UB, LB} : lanes_q;
        range_err_d = new_acc && oor;
        rd_word     = oor_q ? 16'h0000 :
                      mem[addr_q[AW-1:0]] & {{8{!lanes_q[1]}}, {8{!lanes_q[0]}}};
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 18'd0;
            oor_q       <= 1'b0;
            lanes_q     <= 2'b00;
            range_err_q <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            oor_q       <= oor_d;
            lanes_q     <= lanes_d;
            range_err_q <= range_err_d;
            run_q       <= 1'b1;
        end
    end
    // Array is never reset; bus writes are held off until the first edge after reset release.
    // Init is applied last so it overrides a same-edge bus write to the same word.
    always_ff @(posedge Clk) begin
        if (run_q && wr_req && !oor) begin
            if (!LB) mem[ADDR[AW-1:0]][7:0] <= Data[7:0];
            if (!UB) mem[ADDR[AW-1:0]][15:8] <= Data[15:8];
        end
        if (Init_En) mem[Init_Addr] <= Init_Data;
    end
    assign Data_Valid = state_q == RD_DRIVE;
    assign Range_Err  = range_err_q;
    assign Data       = Data_Valid ? rd_word : 16'hzzzz;
endmodule
